// File: rtl/preproc_stream_reader_pkg.sv
// Shared definitions for the pre-processing plane reader: default geometry,
// controller states and the field layout of one output beat.
package preproc_stream_reader_pkg;

    localparam int DEF_IMG_W  = 128;
    localparam int DEF_IMG_H  = 128;
    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_PAD    = 1;

    localparam int COORD_W = 8;

    // Beat layout, LSB first: last flag, column, row, then the three samples.
    localparam int OFF_LAST = 0;
    localparam int OFF_COL  = OFF_LAST + 1;
    localparam int OFF_ROW  = OFF_COL + COORD_W;
    localparam int OFF_DATA = OFF_ROW + COORD_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int beat_w(input int data_w);
        return OFF_DATA + 3 * data_w;
    endfunction

endpackage

// File: rtl/preproc_stream_reader_skid_buf.sv
// Two-entry valid/ready buffer with an empty-and-ready bypass, so an entry
// arriving at an idle output is presented in the same cycle.
module stream_skid_buf #(
    parameter int WIDTH = 41
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       level
);

    logic [WIDTH-1:0] mem [2];
    logic             head;
    logic [1:0]       cnt;
    logic             push;
    logic             pop_mem;
    logic             tail;

    assign level     = cnt;
    assign out_valid = (cnt != 2'd0) || in_valid;
    assign out_data  = (cnt != 2'd0) ? mem[head] : in_data;
    assign pop_mem   = (cnt != 2'd0) && out_ready;
    // The upstream credit check guarantees a free slot whenever push is high.
    assign push      = in_valid && !((cnt == 2'd0) && out_ready);
    assign tail      = head ^ cnt[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= 2'd0;
            head <= 1'b0;
        end else begin
            cnt <= cnt + {1'b0, push} - {1'b0, pop_mem};
            if (pop_mem) begin
                head <= ~head;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= in_data;
        end
    end

endmodule

// File: rtl/preproc_stream_reader.sv
// Streams the three int8 pre-processed planes as one {ch6,ch5,ch4} beat per
// pixel in raster order, optionally framed by a zero border.
module preproc_stream_reader
    import preproc_stream_reader_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int PAD    = DEF_PAD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [DATA_W-1:0]     rd_data_ch4,
    input  logic [DATA_W-1:0]     rd_data_ch5,
    input  logic [DATA_W-1:0]     rd_data_ch6,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [3*DATA_W-1:0]   m_data,
    output logic [7:0]            m_row,
    output logic [7:0]            m_col,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam int BEAT_W = beat_w(DATA_W);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_H + 2 * PAD - 1);
    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_W + 2 * PAD - 1);

    // Border beats carry zero, not the most negative sample.
    function automatic logic [3*DATA_W-1:0] stage1_sample(
        input logic                     is_pad,
        input logic signed [DATA_W-1:0] c4,
        input logic signed [DATA_W-1:0] c5,
        input logic signed [DATA_W-1:0] c6
    );
        return is_pad ? '0 : {c6, c5, c4};
    endfunction

    state_t               state;
    logic [COORD_W-1:0]   pr_p0;
    logic [COORD_W-1:0]   pc_p0;
    logic                 pad_p0;
    logic                 last_p0;
    logic                 issue;
    logic [1:0]           occ;
    logic [1:0]           level;

    logic                 vld_p1;
    logic                 pad_p1;
    logic                 last_p1;
    logic [COORD_W-1:0]   row_p1;
    logic [COORD_W-1:0]   col_p1;
    logic signed [DATA_W-1:0] ch4_p1;
    logic signed [DATA_W-1:0] ch5_p1;
    logic signed [DATA_W-1:0] ch6_p1;

    logic [BEAT_W-1:0]    beat_in;
    logic [BEAT_W-1:0]    beat_out;

    // ---- stage 0: coordinate issue ----
    assign pad_p0  = (PAD != 0) &&
                     ((pr_p0 == '0) || (pr_p0 == LAST_ROW) ||
                      (pc_p0 == '0) || (pc_p0 == LAST_COL));
    assign last_p0 = (pr_p0 == LAST_ROW) && (pc_p0 == LAST_COL);
    // Buffered plus in-flight entries never exceed the two skid slots.
    assign occ     = level + {1'b0, vld_p1};
    assign issue   = (state == RUN) && (occ < 2'd2);
    assign rd_en   = issue && !pad_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            pr_p0   <= '0;
            pc_p0   <= '0;
            rd_addr <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= issue;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        pr_p0   <= '0;
                        pc_p0   <= '0;
                        rd_addr <= '0;
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (rd_en) begin
                            rd_addr <= rd_addr + ADDR_W'(1);
                        end
                        if (last_p0) begin
                            state <= DRAIN;
                        end else if (pc_p0 == LAST_COL) begin
                            pc_p0 <= '0;
                            pr_p0 <= pr_p0 + COORD_W'(1);
                        end else begin
                            pc_p0 <= pc_p0 + COORD_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (m_valid && m_ready && m_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---- stage 1: RAM data returns alongside the issued coordinate ----
    always_ff @(posedge clk) begin
        if (issue) begin
            pad_p1  <= pad_p0;
            last_p1 <= last_p0;
            row_p1  <= pr_p0;
            col_p1  <= pc_p0;
        end
    end

    assign ch4_p1  = rd_data_ch4;
    assign ch5_p1  = rd_data_ch5;
    assign ch6_p1  = rd_data_ch6;
    assign beat_in = vld_p1 ? {stage1_sample(pad_p1, ch4_p1, ch5_p1, ch6_p1),
                               row_p1, col_p1, last_p1}
                            : '0;

    // ---- stage 2: skid buffer to the output port ----
    stream_skid_buf #(
        .WIDTH(BEAT_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (vld_p1),
        .in_data  (beat_in),
        .out_valid(m_valid),
        .out_ready(m_ready),
        .out_data (beat_out),
        .level    (level)
    );

    assign m_data = beat_out[OFF_DATA +: 3*DATA_W];
    assign m_row  = beat_out[OFF_ROW +: COORD_W];
    assign m_col  = beat_out[OFF_COL +: COORD_W];
    assign m_last = beat_out[OFF_LAST];

endmodule

// File: tb/tb_preproc_stream_reader.sv
// Scoreboard bench: a PAD=1 and a PAD=0 reader run against a behavioural
// frame model; a negedge monitor pops and compares every accepted beat.
module tb_preproc_stream_reader;

    localparam int W = 128;
    localparam int H = 128;

    typedef struct packed {
        logic [23:0] data;
        logic [7:0]  row;
        logic [7:0]  col;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] ram4 [W*H];
    logic [7:0] ram5 [W*H];
    logic [7:0] ram6 [W*H];

    logic        start1 = 1'b0, m_ready1 = 1'b0;
    logic        rd_en1, m_valid1, m_last1, busy1, done1;
    logic [13:0] rd_addr1;
    logic [7:0]  r4_1, r5_1, r6_1, m_row1, m_col1;
    logic [23:0] m_data1;

    logic        start0 = 1'b0, m_ready0 = 1'b0;
    logic        rd_en0, m_valid0, m_last0, busy0, done0;
    logic [13:0] rd_addr0;
    logic [7:0]  r4_0, r5_0, r6_0, m_row0, m_col0;
    logic [23:0] m_data0;

    preproc_stream_reader #(.PAD(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .rd_data_ch4(r4_1), .rd_data_ch5(r5_1), .rd_data_ch6(r6_1),
        .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1), .m_row(m_row1),
        .m_col(m_col1), .m_last(m_last1), .busy(busy1), .done(done1)
    );

    preproc_stream_reader #(.PAD(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .rd_en(rd_en0), .rd_addr(rd_addr0),
        .rd_data_ch4(r4_0), .rd_data_ch5(r5_0), .rd_data_ch6(r6_0),
        .m_valid(m_valid0), .m_ready(m_ready0), .m_data(m_data0), .m_row(m_row0),
        .m_col(m_col0), .m_last(m_last0), .busy(busy0), .done(done0)
    );

    always @(posedge clk) begin
        if (rd_en1) begin
            r4_1 <= ram4[rd_addr1];
            r5_1 <= ram5[rd_addr1];
            r6_1 <= ram6[rd_addr1];
        end
        if (rd_en0) begin
            r4_0 <= ram4[rd_addr0];
            r5_0 <= ram5[rd_addr0];
            r6_0 <= ram6[rd_addr0];
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the padded frame in raster order.
    beat_t exp_q1 [$];
    beat_t exp_q0 [$];

    task automatic push_frame(input int g);
        int p;
        p = (g == 1) ? 1 : 0;
        for (int r = 0; r < H + 2 * p; r++) begin
            for (int c = 0; c < W + 2 * p; c++) begin
                beat_t b;
                int    a;
                if (r < p || r >= H + p || c < p || c >= W + p) begin
                    b.data = 24'h0;
                end else begin
                    a = (r - p) * W + (c - p);
                    b.data = {ram6[a], ram5[a], ram4[a]};
                end
                b.row  = 8'(r);
                b.col  = 8'(c);
                b.last = (r == H + 2 * p - 1) && (c == W + 2 * p - 1);
                if (g == 1) exp_q1.push_back(b);
                else        exp_q0.push_back(b);
            end
        end
    endtask

    int          got [2];
    int          idx [2];
    int          rise_cyc [2];
    int          last_cyc [2];
    logic        prev_v [2];
    logic        stall_prev [2];
    logic        done_chk [2];
    beat_t       held [2];
    logic [23:0] cap131 [2];

    initial begin
        for (int g = 0; g < 2; g++) begin
            got[g] = 0; idx[g] = 0; rise_cyc[g] = 0; last_cyc[g] = 0;
            prev_v[g] = 1'b0; stall_prev[g] = 1'b0; done_chk[g] = 1'b0;
            held[g] = '0; cap131[g] = 24'h0;
        end
    end

    task automatic mon(input int g, input logic v, input logic rdy, input beat_t cur,
                       input logic dn, input logic r);
        beat_t e;
        if (r) begin
            stall_prev[g] = 1'b0;
            done_chk[g]   = 1'b0;
            prev_v[g]     = 1'b0;
            idx[g]        = 0;
        end else begin
            if (done_chk[g]) begin
                check("done_after_last", 64'(dn), 64'(1));
                done_chk[g] = 1'b0;
            end
            if (stall_prev[g])
                check("stall_hold", 64'({v, cur}), 64'({1'b1, held[g]}));
            if (v && !prev_v[g]) rise_cyc[g] = cyc;
            prev_v[g] = v;
            if (v && rdy) begin
                if ((g == 1) ? (exp_q1.size() == 0) : (exp_q0.size() == 0)) begin
                    check("extra_beat", 64'(1), 64'(0));
                end else begin
                    e = (g == 1) ? exp_q1.pop_front() : exp_q0.pop_front();
                    if (g == 1) check("beat_pad1", 64'(cur), 64'(e));
                    else        check("beat_pad0", 64'(cur), 64'(e));
                end
                if (idx[g] == 131) cap131[g] = cur.data;
                got[g]++;
                idx[g]++;
                if (cur.last) begin
                    check("done_low_at_last", 64'(dn), 64'(0));
                    last_cyc[g] = cyc;
                    done_chk[g] = 1'b1;
                    idx[g]      = 0;
                end
            end
            stall_prev[g] = v && !rdy;
            held[g]       = cur;
        end
    endtask

    always @(negedge clk) begin
        mon(1, m_valid1, m_ready1, {m_data1, m_row1, m_col1, m_last1}, done1, rst);
        mon(0, m_valid0, m_ready0, {m_data0, m_row0, m_col0, m_last0}, done0, rst);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset1(input string name);
        check(name, 64'({rd_en1, rd_addr1, m_valid1, m_data1, m_row1, m_col1,
                         m_last1, busy1, done1}), 64'(0));
    endtask

    task automatic start_frames(input logic use1, input logic use0, output int t0);
        if (use1) push_frame(1);
        if (use0) push_frame(0);
        start1 = use1;
        start0 = use0;
        t0 = cyc;
        step();
        start1 = 1'b0;
        start0 = 1'b0;
        if (use1) check("busy_done_after_start1", 64'({busy1, done1}), 64'(2'b10));
        if (use0) check("busy_done_after_start0", 64'({busy0, done0}), 64'(2'b10));
    endtask

    task automatic run_until_done(input logic use1, input logic use0, input bit rand_rdy,
                                  input int pulse_at, input int base1);
        int n;
        bit pulsed;
        n = 0;
        pulsed = 1'b0;
        while (!((!use1 || done1) && (!use0 || done0)) && n < 50000) begin
            step();
            n++;
            start1 = 1'b0;
            if (rand_rdy) m_ready1 = 1'($urandom_range(0, 1));
            if (pulse_at >= 0 && !pulsed && (got[1] - base1) >= pulse_at) begin
                start1 = 1'b1;
                pulsed = 1'b1;
            end
        end
        start1 = 1'b0;
        check("frame_timeout", 64'(n < 50000), 64'(1));
    endtask

    initial begin
        int t0, b1, b0, n;
        logic [23:0] c131;
        void'($urandom(32'd20240611));
        for (int a = 0; a < W * H; a++) begin
            ram4[a] = a[7:0];
            ram5[a] = ~a[7:0];
            ram6[a] = a[7:0] ^ 8'h5A;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset1("reset_outputs1");
        check("reset_outputs0", 64'({rd_en0, rd_addr0, m_valid0, m_data0, m_row0, m_col0,
                                     m_last0, busy0, done0}), 64'(0));
        rst = 1'b0;
        step();

        // Full-throughput frames on both instances side by side.
        m_ready1 = 1'b1;
        m_ready0 = 1'b1;
        b1 = got[1];
        b0 = got[0];
        start_frames(1'b1, 1'b1, t0);
        run_until_done(1'b1, 1'b1, 1'b0, -1, b1);
        check("beats_pad1", 64'(got[1] - b1), 64'(16900));
        check("beats_pad0", 64'(got[0] - b0), 64'(16384));
        check("left_pad1", 64'(exp_q1.size()), 64'(0));
        check("left_pad0", 64'(exp_q0.size()), 64'(0));
        check("latency_pad1", 64'(rise_cyc[1] - t0), 64'(2));
        check("latency_pad0", 64'(rise_cyc[0] - t0), 64'(2));
        check("no_bubble_pad1", 64'(last_cyc[1] - rise_cyc[1]), 64'(16899));
        check("no_bubble_pad0", 64'(last_cyc[0] - rise_cyc[0]), 64'(16383));
        check("beat131_pad1", 64'(cap131[1]), 64'(24'h5AFF00));
        check("idle_after_frame1", 64'({busy1, done1}), 64'(2'b01));

        // Replay from DONE with a -128 sample, random backpressure, stray start.
        ram4[0] = 8'h80;
        b1 = got[1];
        start_frames(1'b1, 1'b0, t0);
        run_until_done(1'b1, 1'b0, 1'b1, 500, b1);
        check("beats_random", 64'(got[1] - b1), 64'(16900));
        check("left_random", 64'(exp_q1.size()), 64'(0));
        c131 = cap131[1];
        check("neg128_passthru", 64'(c131[7:0]), 64'(8'h80));
        m_ready1 = 1'b1;
        step();

        // Abort mid-frame under backpressure, then a clean frame.
        b1 = got[1];
        start_frames(1'b1, 1'b0, t0);
        n = 0;
        while ((got[1] - b1) < 7000 && n < 20000) begin
            step();
            n++;
        end
        m_ready1 = 1'b0;
        repeat (3) step();
        check("stalled_valid", 64'(m_valid1), 64'(1));
        rst = 1'b1;
        #1;
        check_reset1("reset_midframe");
        exp_q1.delete();
        step();
        rst = 1'b0;
        m_ready1 = 1'b1;
        repeat (3) step();
        check_reset1("quiet_after_reset");
        b1 = got[1];
        start_frames(1'b1, 1'b0, t0);
        run_until_done(1'b1, 1'b0, 1'b0, -1, b1);
        check("beats_after_reset", 64'(got[1] - b1), 64'(16900));
        check("left_after_reset", 64'(exp_q1.size()), 64'(0));
        check("latency_after_reset", 64'(rise_cyc[1] - t0), 64'(2));
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
